// File: rtl/gemm_dot_accum.sv
// Multi-lane signed dot-product accumulator: LANES products per beat, registered
// adder tree, K-beat accumulation onto an initial sum, valid/ready result output.
module gemm_dot_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int K_WIDTH    = 16
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic                          istart,
  input  logic [K_WIDTH-1:0]            icfg_k_len,
  input  logic                          icfg_saturate,
  input  logic [ACC_WIDTH-1:0]          iinit_sum,
  input  logic                          ivalid,
  output logic                          oready,
  input  logic [LANES*DATA_WIDTH-1:0]   ia_vec,
  input  logic [LANES*DATA_WIDTH-1:0]   ib_vec,
  output logic [ACC_WIDTH-1:0]          osum,
  output logic                          osum_valid,
  input  logic                          iosum_ready,
  output logic                          obusy,
  output logic                          ooverflow
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [K_WIDTH-1:0]          r_k_len;
  logic [K_WIDTH-1:0]          r_cnt;
  logic                        r_sat;
  logic                        r_p1_valid;
  logic                        r_p2_valid;
  logic signed [PROD_W-1:0]    r_prod [LANES];
  logic signed [PROD_W-1:0]    w_prod [LANES];
  logic signed [SUM_W-1:0]     w_tree;
  logic signed [SUM_W-1:0]     r_sum;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH:0]   w_wide;
  logic                        w_ovf;
  logic [ACC_WIDTH-1:0]        w_acc_next;
  logic [ACC_WIDTH-1:0]        r_acc;
  logic                        r_ovf;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_load;

  assign w_accept = ivalid && (r_state == S_ACCUM);
  assign w_last   = w_accept && ((r_cnt + K_WIDTH'(1)) == r_k_len);
  assign w_load   = istart && (r_state == S_IDLE);

  always_ff @(posedge iclk) begin
    if (irst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    oready     = 1'b0;
    obusy      = 1'b1;
    osum_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        obusy = 1'b0;
        if (istart) w_next = (icfg_k_len == '0) ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        oready = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_p1_valid && !r_p2_valid) w_next = S_HOLD;
      end
      S_HOLD: begin
        osum_valid = 1'b1;
        if (iosum_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      w_prod[i] = PROD_W'($signed(ia_vec[i*DATA_WIDTH +: DATA_WIDTH]))
                * PROD_W'($signed(ib_vec[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_comb begin
    w_tree = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_tree = w_tree + SUM_W'(r_prod[i]);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_p1_valid <= 1'b0;
      r_p2_valid <= 1'b0;
    end else begin
      r_p1_valid <= w_accept;
      r_p2_valid <= r_p1_valid;
    end
    if (w_accept) begin
      for (int unsigned i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
    end
    if (r_p1_valid) r_sum <= w_tree;
  end

  // One guard bit: overflow is a mismatch between the guard and the result sign.
  assign w_ext  = ACC_WIDTH'(r_sum);
  assign w_wide = $signed({r_acc[ACC_WIDTH-1], r_acc}) + $signed({w_ext[ACC_WIDTH-1], w_ext});
  assign w_ovf  = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_wide[ACC_WIDTH-1:0];
    if (w_ovf && r_sat) w_acc_next = w_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_k_len <= '0;
      r_sat   <= 1'b0;
    end else if (w_load) begin
      r_acc   <= iinit_sum;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_k_len <= icfg_k_len;
      r_sat   <= icfg_saturate;
    end else begin
      if (w_accept) r_cnt <= r_cnt + K_WIDTH'(1);
      if (r_p2_valid) begin
        r_acc <= w_acc_next;
        if (w_ovf) r_ovf <= 1'b1;
      end
    end
  end

  assign osum      = r_acc;
  assign ooverflow = r_ovf;

endmodule

// File: tb/tb_gemm_dot_accum.sv
// Directed and randomized checks of gemm_dot_accum against a plain-arithmetic job model.
module tb_gemm_dot_accum;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        istart = 1'b0;
  logic [15:0] k_len = '0;
  logic        sat = 1'b0;
  logic [47:0] init_sum = '0;
  logic        ivalid = 1'b0;
  logic [63:0] a_vec = '0;
  logic [63:0] b_vec = '0;
  logic        iosum_ready = 1'b0;

  logic        oready0, osum_valid0, obusy0, ooverflow0;
  logic [47:0] osum0;
  logic        oready1, osum_valid1, obusy1, ooverflow1;
  logic [33:0] osum1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];

  gemm_dot_accum #(.DATA_WIDTH(16), .LANES(4), .ACC_WIDTH(48), .K_WIDTH(16)) dut0 (
    .iclk(iclk), .irst(irst), .istart(istart), .icfg_k_len(k_len),
    .icfg_saturate(sat), .iinit_sum(init_sum), .ivalid(ivalid), .oready(oready0),
    .ia_vec(a_vec), .ib_vec(b_vec), .osum(osum0), .osum_valid(osum_valid0),
    .iosum_ready(iosum_ready), .obusy(obusy0), .ooverflow(ooverflow0)
  );

  gemm_dot_accum #(.DATA_WIDTH(16), .LANES(4), .ACC_WIDTH(34), .K_WIDTH(16)) dut1 (
    .iclk(iclk), .irst(irst), .istart(istart), .icfg_k_len(k_len),
    .icfg_saturate(sat), .iinit_sum(init_sum[33:0]), .ivalid(ivalid), .oready(oready1),
    .ia_vec(a_vec), .ib_vec(b_vec), .osum(osum1), .osum_valid(osum_valid1),
    .iosum_ready(iosum_ready), .obusy(obusy1), .ooverflow(ooverflow1)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  // Accumulate the queued beats onto init with the width/saturation rules.
  function automatic logic signed [63:0] ref_job(input longint init, input int w,
                                                 input bit do_sat, output bit ovf);
    longint acc, mx, mn, v, p, span;
    logic [63:0] av, bv;
    logic signed [15:0] x, y;
    span = longint'(1) << w;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    acc = init;
    ovf = 1'b0;
    foreach (qa[i]) begin
      av = qa[i];
      bv = qb[i];
      p = 0;
      for (int l = 0; l < 4; l++) begin
        x = av[l*16 +: 16];
        y = bv[l*16 +: 16];
        p += longint'(x) * longint'(y);
      end
      v = acc + p;
      if (v > mx || v < mn) begin
        ovf = 1'b1;
        if (do_sat) v = (v > mx) ? mx : mn;
        else begin
          v = v & (span - 1);
          if (v > mx) v -= span;
        end
      end
      acc = v;
    end
    return acc;
  endfunction

  task automatic start_job(input int k, input longint init, input bit s);
    qa.delete();
    qb.delete();
    k_len = 16'(k);
    init_sum = init[47:0];
    sat = s;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    chk("obusy_after_start", obusy0, 1);
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input int gap);
    chk("oready_in_accum", oready0, 1);
    qa.push_back(a);
    qb.push_back(b);
    a_vec = a;
    b_vec = b;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int lat);
    int cnt = 0;
    while (osum_valid0 !== 1'b1 && cnt < 30) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, lat);
  endtask

  task automatic handshake();
    iosum_ready = 1'b1;
    tick();
    iosum_ready = 1'b0;
    chk("valid_drop", osum_valid0, 0);
    chk("obusy_drop", obusy0, 0);
  endtask

  initial begin
    logic signed [63:0] exp0, exp1, held;
    bit ovf0, ovf1, saw_valid;
    logic [63:0] ones, twos, neg;
    int k;
    longint init;
    bit s;

    repeat (3) tick();
    chk("rst_oready", oready0, 0);
    chk("rst_obusy", obusy0, 0);
    chk("rst_valid", osum_valid0, 0);
    chk("rst_osum", $signed(osum0), 0);
    chk("rst_ovf", ooverflow0, 0);
    irst = 1'b0;
    tick();

    // k=1 basic dot product, latency from last beat
    start_job(1, 0, 0);
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0);
    wait_done("lat_k1", 3);
    exp0 = ref_job(0, 48, 0, ovf0);
    chk("k1_model", $signed(osum0), exp0);
    chk("k1_const", $signed(osum0), 70);
    chk("k1_ovf", ooverflow0, 0);
    handshake();

    // k=3 with gaps between beats
    ones = pack4(1, 1, 1, 1);
    twos = pack4(2, 2, 2, 2);
    start_job(3, 100, 0);
    send_beat(ones, twos, 1);
    send_beat(ones, twos, 1);
    send_beat(ones, twos, 0);
    chk("oready_after_last", oready0, 0);
    wait_done("lat_k3", 3);
    chk("k3_const", $signed(osum0), 124);
    handshake();

    // 34-bit instance: saturate then wrap
    neg = 64'h8000_8000_8000_8000;
    for (int m = 1; m >= 0; m--) begin
      start_job(2, 0, m[0]);
      send_beat(neg, neg, 0);
      send_beat(neg, neg, 0);
      wait_done("lat_sat", 3);
      exp1 = ref_job(0, 34, m[0], ovf1);
      exp0 = ref_job(0, 48, m[0], ovf0);
      chk("w34_osum", $signed(osum1), exp1);
      chk("w34_const", $signed(osum1), m[0] ? 64'sd8589934591 : -64'sd8589934592);
      chk("w34_ovf", ooverflow1, 1);
      chk("w34_valid", osum_valid1, 1);
      chk("w34_oready", oready1, 0);
      chk("w34_obusy", obusy1, 1);
      chk("w48_osum", $signed(osum0), exp0);
      chk("w48_ovf", ooverflow0, ovf0);
      handshake();
    end

    // k=0: result is the initial sum two cycles after istart
    start_job(0, -5, 0);
    chk("k0_oready", oready0, 0);
    chk("k0_notvalid", osum_valid0, 0);
    tick();
    chk("k0_valid", osum_valid0, 1);
    chk("k0_osum", $signed(osum0), -5);

    // HOLD: istart and ivalid ignored, output stable
    held = $signed(osum0);
    for (int c = 0; c < 10; c++) begin
      istart = c[0];
      k_len = 16'd2;
      init_sum = 48'd12345;
      ivalid = 1'b1;
      a_vec = {$urandom, $urandom};
      b_vec = {$urandom, $urandom};
      tick();
      chk("hold_osum", $signed(osum0), held);
      chk("hold_valid", osum_valid0, 1);
      chk("hold_oready", oready0, 0);
    end
    istart = 1'b0;
    ivalid = 1'b0;
    handshake();
    chk("idle_keeps_osum", $signed(osum0), held);

    // reset mid-job
    start_job(4, 77, 0);
    send_beat(pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 0);
    send_beat(pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 0);
    irst = 1'b1;
    tick();
    chk("mrst_oready", oready0, 0);
    chk("mrst_obusy", obusy0, 0);
    chk("mrst_valid", osum_valid0, 0);
    chk("mrst_osum", $signed(osum0), 0);
    chk("mrst_ovf", ooverflow0, 0);
    irst = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin
      tick();
      if (osum_valid0 === 1'b1) saw_valid = 1'b1;
    end
    chk("mrst_no_valid", saw_valid, 0);
    start_job(1, -9, 0);
    send_beat(pack4(-2, 4, 7, 0), pack4(10, -3, 5, 9), 0);
    wait_done("lat_after_rst", 3);
    exp0 = ref_job(-9, 48, 0, ovf0);
    chk("after_rst_osum", $signed(osum0), exp0);
    handshake();

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      k = $urandom_range(1, 6);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: init = longint'($signed(16'($urandom)));
        1: init = (longint'(1) << 47) - 1 - longint'($urandom_range(0, 32'h4000_0000));
        default: init = -(longint'(1) << 47) + longint'($urandom_range(0, 32'h4000_0000));
      endcase
      start_job(k, init, s);
      for (int b = 0; b < k; b++) begin
        send_beat({$urandom, $urandom}, {$urandom, $urandom},
                  (b == k - 1) ? 0 : $urandom_range(0, 2));
      end
      wait_done("lat_rand", 3);
      exp0 = ref_job(init, 48, s, ovf0);
      chk("rand_osum", $signed(osum0), exp0);
      chk("rand_ovf", ooverflow0, ovf0);
      handshake();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
